// File: rtl/layer_out_serializer.sv
// Streams a captured layer result vector out one element at a time,
// requantizing each element by arithmetic shift and saturation.
// Define LAYER_OUT_SER_ROUND_EN to round half-up before the shift.
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : capture handshake for in_data
//   in_data              : NEURON_NUM signed elements, element 0 at LSBs
//   out_valid/out_ready  : element handshake
//   out_data             : requantized element
//   out_index/out_last   : element index, high on the final element
//   sat_cnt              : saturated elements seen in the current vector
module layer_out_serializer #(
    parameter int LAYER_DATA_WIDTH = 8,
    parameter int NEURON_NUM       = 4,
    parameter int SHIFT            = 4,
    parameter int IDX_W            = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [NEURON_NUM*(LAYER_DATA_WIDTH+8)-1:0] in_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic signed [LAYER_DATA_WIDTH-1:0]            out_data,
    output logic [IDX_W-1:0]                              out_index,
    output logic                                          out_last,
    output logic [15:0]                                   sat_cnt
);

    localparam int EW = LAYER_DATA_WIDTH + 8;
    localparam int XW = LAYER_DATA_WIDTH + 9;

    localparam logic signed [XW-1:0] MAXV =
        XW'((1 << (LAYER_DATA_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = ~MAXV;
    localparam logic signed [XW-1:0] BIAS =
        (SHIFT > 0) ? (XW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_nx;

    logic signed [EW-1:0] buf_q [NEURON_NUM];
    logic [IDX_W-1:0]     idx_q;
    logic [15:0]          sat_q;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] x_b;
    logic signed [XW-1:0] y;
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 is_sat;
    logic                 is_last;
    logic                 cap;
    logic                 fire;
    logic [LAYER_DATA_WIDTH-1:0] q_data;

    // One extra bit of headroom so the rounding bias cannot overflow.
    always_comb begin
        x_ext = {buf_q[idx_q][EW-1], buf_q[idx_q]};
`ifdef LAYER_OUT_SER_ROUND_EN
        x_b = x_ext + BIAS;
`else
        x_b = x_ext;
`endif
        y      = x_b >>> SHIFT;
        sat_hi = (y > MAXV);
        sat_lo = (y < MINV);
        is_sat = sat_hi || sat_lo;
        if (sat_hi) begin
            q_data = MAXV[LAYER_DATA_WIDTH-1:0];
        end else if (sat_lo) begin
            q_data = MINV[LAYER_DATA_WIDTH-1:0];
        end else begin
            q_data = y[LAYER_DATA_WIDTH-1:0];
        end
    end

    assign is_last   = (idx_q == IDX_W'(NEURON_NUM - 1));
    assign out_index = idx_q;
    assign out_last  = (state == SEND) && is_last;
    assign out_data  = (state == SEND) ? q_data : '0;
    assign sat_cnt   = sat_q;
    assign cap       = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && is_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx_q <= '0;
            sat_q <= '0;
            for (int i = 0; i < NEURON_NUM; i++) buf_q[i] <= '0;
        end else begin
            state <= state_nx;
            if (cap) begin
                for (int i = 0; i < NEURON_NUM; i++) begin
                    buf_q[i] <= in_data[i*EW +: EW];
                end
                idx_q <= '0;
                sat_q <= '0;
            end else if (fire) begin
                if (is_sat && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
                idx_q <= is_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Randomized bench for layer_out_serializer against a queue-based model
// of the requantized element stream and the per-vector saturation count.
module tb_layer_out_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic signed [7:0] out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic [15:0] sat_cnt;

    int total = 0;
    int bad   = 0;
    int rmode = 0;
    int bp    = 0;

    typedef struct {
        int d;
        int idx;
        bit last;
        bit s;
    } exp_t;

    exp_t q[$];
    int   sat_m = 0;

    layer_out_serializer #(
        .LAYER_DATA_WIDTH(8),
        .NEURON_NUM(4),
        .SHIFT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Floor (or round-half-up) division by 2^SHIFT, then clamp to int8.
    function automatic int rq(input int x, output bit s);
        int d;
        int y;
        d = 16;
`ifdef LAYER_OUT_SER_ROUND_EN
        x = x + d / 2;
`endif
        if (x >= 0) y = x / d;
        else y = -((-x + d - 1) / d);
        s = 1'b0;
        if (y > 127) begin
            y = 127;
            s = 1'b1;
        end else if (y < -128) begin
            y = -128;
            s = 1'b1;
        end
        return y;
    endfunction

    function automatic logic [63:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ov", out_valid, 0);
            q.delete();
            sat_m = 0;
        end else begin
            chk("valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() == 0);
            chk("sat_cnt", sat_cnt, sat_m);
            if (out_valid && q.size() != 0) begin
                chk("data", out_data, q[0].d);
                chk("index", out_index, q[0].idx);
                chk("last", out_last, q[0].last);
                if (out_ready) begin
                    if (q[0].s && sat_m != 65535) sat_m++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < 4; i++) begin
                    logic signed [15:0] v;
                    exp_t e;
                    v = in_data[i*16 +: 16];
                    e.d = rq(int'(v), e.s);
                    e.idx = i;
                    e.last = (i == 3);
                    q.push_back(e);
                end
                sat_m = 0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: out_ready = ($urandom % 3) != 0;
                2: begin
                    if (out_valid && out_index == 2'd1 && bp < 3) begin
                        out_ready = 1'b0;
                        bp++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send_vec(input logic [63:0] v);
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || n > 200) break;
            n++;
        end
        if (n > 200) chk("cap_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid && n < 300);
        if (out_valid) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rmode = 0;
        send_vec(pk(160, 24, -17, 0));
        wait_idle();

        send_vec(pk(4000, -4000, 2047, -2048));
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        bp = 0;
        rmode = 2;
        send_vec(pk(160, 24, -17, 0));
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = pk(1000, 1000, 1000, 1000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        chk("bp_cycles", bp, 3);
        rmode = 0;

        send_vec(pk(24, -17, 8, -8));
        wait_idle();

        send_vec(pk(4000, 24, -4000, 7));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_index == 2'd1) && n < 50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_ir", in_ready, 1);
        chk("mid_rst_sat", sat_cnt, 0);
        chk("mid_rst_idx", out_index, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_vec(pk(-300, 33, 2100, -2100));
        wait_idle();

        send_vec(pk(16, 32, 48, 64));
        send_vec(pk(-16, -32, -48, -64));
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            rmode = int'($urandom % 2);
            send_vec({$urandom, $urandom});
            if ($urandom % 2) wait_idle();
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end
        rmode = 0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        chk("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
